oled_spi_rx: RTL and testbench
==============================

# oled_spi_rx

SPI receiver and display-side decoder for the PmodOLED command/data stream. Sits on the CS/SDO/SCLK/DC lines driven by the OLED controller and reassembles bytes MSB-first. It decodes the page and column addressing commands and writes data bytes into a 4-page × 128-column shadow frame buffer. A read port on that buffer lets the same design mirror the OLED contents to other outputs, such as VGA or a debug tap, and lets benches check screen contents without a panel model.

## Interface
- SYNC_STAGES, 2, flops in each input synchronizer (≥2)
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-low
- CS  in  1  SPI chip select, active-low, async to CLK
- SCLK  in  1  SPI clock, idles high, async to CLK
- SDO  in  1  SPI serial data from controller
- DC  in  1  0 = command byte, 1 = data byte
- RD_ADDR  in  9  frame buffer read address {page[1:0], col[6:0]}
- RD_DATA  out  8  frame buffer read data, registered
- BYTE_VALID  out  1  one-cycle pulse per completed byte
- BYTE_DATA  out  8  last completed byte
- BYTE_DC  out  1  DC value captured with last byte
- CUR_PAGE  out  2  current write page
- CUR_COL  out  7  current write column
- CMD_UNK  out  1  one-cycle pulse on an unrecognised command byte
- DISP_ON  out  1  display-on flag (see Configuration)

## Operation
- CS, SCLK, SDO and DC each pass through a SYNC_STAGES-deep synchronizer. SCLK rising edges are detected on the synchronized value.
- While synchronized CS = 0, each SCLK rising edge shifts SDO into an 8-bit register, MSB first, and increments a 3-bit counter.
- On the 8th bit:
  - BYTE_DATA and BYTE_DC load; BYTE_DC takes DC as sampled on that same edge.
  - BYTE_VALID pulses.
  - The counter returns to 0.
- CS high at any time clears the bit counter and discards any partial byte. Edges seen while CS is high are ignored.
- Decoder states are CMD_IDLE and CMD_PAGE_ARG.
- Command bytes (DC = 0) in CMD_IDLE:
  - 0x00–0x0F: CUR_COL[3:0] ← byte[3:0].
  - 0x10–0x1F: CUR_COL[6:4] ← byte[2:0].
  - 0x22: go to CMD_PAGE_ARG.
  - Anything else: CMD_UNK pulses, no state change. The exception is the display commands when OLED_RX_DISPLAY_CMD_EN is defined.
- In CMD_PAGE_ARG:
  - Next command byte: CUR_PAGE ← byte[1:0], return to CMD_IDLE.
  - A data byte instead: return to CMD_IDLE, then handle the data byte normally.
- Data bytes (DC = 1), in any state:
  - Frame buffer write: mem[{CUR_PAGE, CUR_COL}] ← byte.
  - CUR_COL increments, wrapping 127 → 0; CUR_PAGE is unchanged.
- Frame buffer: 512 × 8, one write port (decoder) and one read port (RD_ADDR).

## Timing
- Reset values:
  - CUR_PAGE = 0, CUR_COL = 0, state CMD_IDLE, bit counter 0.
  - BYTE_DATA = 0x00, BYTE_DC = 0, BYTE_VALID = 0, CMD_UNK = 0, RD_DATA = 0x00, DISP_ON = 0.
  - Frame buffer contents are not reset.
- Reset mid-byte drops the partial byte. Reset is asserted asynchronously; deassertion is synchronized internally.
- Input rules:
  - SCLK high and low phases must each be ≥ SYNC_STAGES+1 CLK cycles.
  - SDO and DC must be stable across the SCLK rising edge.
  - CS must stay low ≥ 1 SCLK period after the last rising edge.
- BYTE_VALID asserts SYNC_STAGES+1 CLK cycles after the 8th SCLK rising edge at the pins. It is high for exactly one cycle.
- Decode happens in the BYTE_VALID cycle:
  - The frame buffer write and the CUR_PAGE/CUR_COL/state updates take effect on the following CLK edge.
  - CMD_UNK is coincident with BYTE_VALID.
- RD_DATA has 1-cycle latency from RD_ADDR.
- A read and a write to the same address in the same cycle return the old data.

## Configuration
- OLED_RX_DISPLAY_CMD_EN defined: commands 0xAE/0xAF clear/set DISP_ON on the cycle after BYTE_VALID. These commands do not pulse CMD_UNK.
- OLED_RX_DISPLAY_CMD_EN not defined: DISP_ON is tied to 1. 0xAE/0xAF pulse CMD_UNK like any other unrecognised command.

## Test plan
- Page set: send cmd 0x22, cmd 0x02, cmd 0x00, cmd 0x10, then data 0xA5 → CUR_PAGE = 2; mem[0x100] = 0xA5; CUR_COL = 1 afterwards; no CMD_UNK.
- Column wrap: with page 1 and col 0x7F (cmds 0x0F, 0x17), send data 0x11, 0x22 → mem[0x0FF] = 0x11, mem[0x080] = 0x22, CUR_COL = 1, CUR_PAGE = 1.
- Partial byte: raise CS after 5 bits of 0xFF, then send full data byte 0x3C → exactly one BYTE_VALID, with BYTE_DATA = 0x3C; nothing from the partial byte is written.
- Page-arg abort: cmd 0x22 followed by data 0x77 → state returns to CMD_IDLE; 0x77 is written at the current {page, col}; CUR_PAGE is unchanged.
- Unknown/display commands: send cmd 0xAF then 0x81 → with the macro, DISP_ON = 1 and a single CMD_UNK pulse (for 0x81); without the macro, two CMD_UNK pulses and DISP_ON stays 1.
- Reset mid-stream: assert RST during bit 4 of a data byte → all outputs return to reset values; the next complete byte after release decodes correctly.

Source files
------------

// File: rtl/oled_spi_rx.sv
// oled_spi_rx: PmodOLED SPI receiver, command decoder and 4x128 shadow frame buffer.
// Optional feature macro: OLED_RX_DISPLAY_CMD_EN (0xAE/0xAF drive the display-on flag).
// Without the macro the display-on flag is tied high and 0xAE/0xAF are unknown commands.

module oled_spi_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       cs_ni,
   input  logic       sclk_i,
   input  logic       sdo_i,
   input  logic       dc_i,
   input  logic [8:0] rd_addr_i,
   output logic [7:0] rd_data_o,
   output logic       byte_valid_o,
   output logic [7:0] byte_data_o,
   output logic       byte_dc_o,
   output logic [1:0] cur_page_o,
   output logic [6:0] cur_col_o,
   output logic       cmd_unk_o,
   output logic       disp_on_o
);

   localparam logic [0:0] CMD_IDLE     = 1'b0;
   localparam logic [0:0] CMD_PAGE_ARG = 1'b1;

   logic [1:0]             rstSync_q;
   logic                   rstInt_n;
   logic [SYNC_STAGES-1:0] csSync_q;
   logic [SYNC_STAGES-1:0] sclkSync_q;
   logic [SYNC_STAGES-1:0] sdoSync_q;
   logic [SYNC_STAGES-1:0] dcSync_q;
   logic                   csS;
   logic                   sclkS;
   logic                   sdoS;
   logic                   dcS;
   logic                   sclkPrev_q;
   logic                   sclkRise;
   logic [2:0]             bitCnt_q;
   logic [6:0]             shift_q;
   logic [7:0]             newByte;
   logic [7:0]             byteData_q;
   logic                   byteDc_q;
   logic                   byteValid_q;
   logic [0:0]             state_q;
   logic [0:0]             state_d;
   logic [1:0]             page_q;
   logic [1:0]             page_d;
   logic [6:0]             col_q;
   logic [6:0]             col_d;
   logic                   memWe;
   logic                   cmdUnk;
   logic [7:0]             mem [512];
   logic [7:0]             rdData_q;
`ifdef OLED_RX_DISPLAY_CMD_EN
   logic                   dispOn_q;
   logic                   dispOn_d;
`endif

   // Reset asserts immediately but releases only on a clock edge so all flops leave reset together
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rstSync_q <= 2'b00;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstInt_n = rstSync_q[1];

   // Bring the asynchronous SPI pins into the clock domain; CS and SCLK rest at their idle-high levels
   always_ff @(posedge clk_i or negedge rstInt_n) begin
      if (!rstInt_n) begin
         csSync_q   <= '1;
         sclkSync_q <= '1;
         sdoSync_q  <= '0;
         dcSync_q   <= '0;
      end else begin
         csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_ni};
         sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_i};
         sdoSync_q  <= {sdoSync_q[SYNC_STAGES-2:0], sdo_i};
         dcSync_q   <= {dcSync_q[SYNC_STAGES-2:0], dc_i};
      end
   end

   assign csS      = csSync_q[SYNC_STAGES-1];
   assign sclkS    = sclkSync_q[SYNC_STAGES-1];
   assign sdoS     = sdoSync_q[SYNC_STAGES-1];
   assign dcS      = dcSync_q[SYNC_STAGES-1];
   assign sclkRise = sclkS & ~sclkPrev_q;
   assign newByte  = {shift_q, sdoS};

   // Shift bits MSB-first on each selected SCLK rise and publish the byte with a one-cycle strobe on the eighth bit
   always_ff @(posedge clk_i or negedge rstInt_n) begin
      if (!rstInt_n) begin
         sclkPrev_q  <= 1'b1;
         bitCnt_q    <= 3'd0;
         shift_q     <= 7'd0;
         byteData_q  <= 8'h00;
         byteDc_q    <= 1'b0;
         byteValid_q <= 1'b0;
      end else begin
         sclkPrev_q  <= sclkS;
         byteValid_q <= 1'b0;
         if (csS) begin
            bitCnt_q <= 3'd0;
         end else if (sclkRise) begin
            shift_q  <= newByte[6:0];
            bitCnt_q <= bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
               byteData_q  <= newByte;
               byteDc_q    <= dcS;
               byteValid_q <= 1'b1;
            end
         end
      end
   end

   // Decode the freshly completed byte into address, page-argument and display updates
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      col_d   = col_q;
      memWe   = 1'b0;
      cmdUnk  = 1'b0;
`ifdef OLED_RX_DISPLAY_CMD_EN
      dispOn_d = dispOn_q;
`endif
      if (byteValid_q) begin
         if (byteDc_q) begin
            memWe   = 1'b1;
            col_d   = col_q + 7'd1;
            state_d = CMD_IDLE;
         end else if (state_q == CMD_PAGE_ARG) begin
            page_d  = byteData_q[1:0];
            state_d = CMD_IDLE;
         end else if (byteData_q[7:4] == 4'h0) begin
            col_d = {col_q[6:4], byteData_q[3:0]};
         end else if (byteData_q[7:4] == 4'h1) begin
            col_d = {byteData_q[2:0], col_q[3:0]};
         end else if (byteData_q == 8'h22) begin
            state_d = CMD_PAGE_ARG;
`ifdef OLED_RX_DISPLAY_CMD_EN
         end else if (byteData_q == 8'hAE) begin
            dispOn_d = 1'b0;
         end else if (byteData_q == 8'hAF) begin
            dispOn_d = 1'b1;
`endif
         end else begin
            cmdUnk = 1'b1;
         end
      end
   end

   // Commit decoder state one edge after the byte strobe
   always_ff @(posedge clk_i or negedge rstInt_n) begin
      if (!rstInt_n) begin
         state_q <= CMD_IDLE;
         page_q  <= 2'd0;
         col_q   <= 7'd0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         col_q   <= col_d;
      end
   end

`ifdef OLED_RX_DISPLAY_CMD_EN
   // Display-on flag follows the 0xAE/0xAF commands
   always_ff @(posedge clk_i or negedge rstInt_n) begin
      if (!rstInt_n) begin
         dispOn_q <= 1'b0;
      end else begin
         dispOn_q <= dispOn_d;
      end
   end

   assign disp_on_o = dispOn_q;
`else
   assign disp_on_o = 1'b1;
`endif

   // Frame buffer write port; contents deliberately survive reset
   always_ff @(posedge clk_i) begin
      if (memWe) begin
         mem[{page_q, col_q}] <= byteData_q;
      end
   end

   // Registered read port; a same-cycle write to the read address returns the previous contents
   always_ff @(posedge clk_i or negedge rstInt_n) begin
      if (!rstInt_n) begin
         rdData_q <= 8'h00;
      end else begin
         rdData_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o    = rdData_q;
   assign byte_valid_o = byteValid_q;
   assign byte_data_o  = byteData_q;
   assign byte_dc_o    = byteDc_q;
   assign cur_page_o   = page_q;
   assign cur_col_o    = col_q;
   assign cmd_unk_o    = cmdUnk;

endmodule

// File: tb/tb_oled_spi_rx.sv
// tb_oled_spi_rx: self-checking bench for oled_spi_rx (table vectors, corner sequences, random stream vs model).
`timescale 1ns/1ps

module tb_oled_spi_rx;

   typedef struct {
      bit         isData;
      logic [7:0] b;
      int         expPage;
      int         expCol;
      int         expUnk;
      int         chkAddr;
      int         chkData;
   } vec_t;

`ifdef OLED_RX_DISPLAY_CMD_EN
   localparam bit dispCmdEn = 1'b1;
`else
   localparam bit dispCmdEn = 1'b0;
`endif
   localparam bit resetDisp = dispCmdEn ? 1'b0 : 1'b1;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs_n;
   logic       sclk;
   logic       sdo;
   logic       dc;
   logic [8:0] rdAddr;
   logic [7:0] rdData;
   logic       byteValid;
   logic [7:0] byteData;
   logic       byteDc;
   logic [1:0] curPage;
   logic [6:0] curCol;
   logic       cmdUnk;
   logic       dispOn;

   int         compares = 0;
   int         failures = 0;
   int         validCount = 0;
   int         unkCount = 0;
   int         strayUnk = 0;
   bit         prevValid = 1'b0;
   logic [7:0] rdAfterValid = 8'h00;

   int         mPage;
   int         mCol;
   bit         mArg;
   bit         mDisp;
   logic [7:0] mMem [512];
   bit         mWritten [512];

   oled_spi_rx #(.SYNC_STAGES(2)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cs_ni       (cs_n),
      .sclk_i      (sclk),
      .sdo_i       (sdo),
      .dc_i        (dc),
      .rd_addr_i   (rdAddr),
      .rd_data_o   (rdData),
      .byte_valid_o(byteValid),
      .byte_data_o (byteData),
      .byte_dc_o   (byteDc),
      .cur_page_o  (curPage),
      .cur_col_o   (curCol),
      .cmd_unk_o   (cmdUnk),
      .disp_on_o   (dispOn)
   );

   always #5 clk = ~clk;

   // Count strobes on the falling edge, away from the edge where outputs change
   always @(negedge clk) begin
      if (prevValid) rdAfterValid = rdData;
      prevValid = byteValid;
      if (byteValid) validCount++;
      if (cmdUnk) begin
         unkCount++;
         if (!byteValid) strayUnk++;
      end
   end

   // Absolute time limit so a stuck run still ends
   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compares, failures);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      compares++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Behavioural model of one decoded byte
   task automatic modelByte(input bit isData, input logic [7:0] b, output int unk);
      int addr;
      unk = 0;
      if (isData) begin
         addr = mPage * 128 + mCol;
         mMem[addr] = b;
         mWritten[addr] = 1'b1;
         mCol = (mCol + 1) % 128;
         mArg = 1'b0;
      end else if (mArg) begin
         mPage = b % 4;
         mArg = 1'b0;
      end else if (b < 16) begin
         mCol = (mCol / 16) * 16 + (b % 16);
      end else if (b < 32) begin
         mCol = (b % 8) * 16 + (mCol % 16);
      end else if (b == 8'h22) begin
         mArg = 1'b1;
      end else if (dispCmdEn && (b == 8'hAE || b == 8'hAF)) begin
         mDisp = (b == 8'hAF);
      end else begin
         unk = 1;
      end
   endtask

   task automatic modelReset();
      mPage = 0;
      mCol = 0;
      mArg = 1'b0;
      mDisp = resetDisp;
   endtask

   task automatic shiftBits(input bit isData, input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         sclk = 1'b0;
         sdo  = b[7-i];
         dc   = isData;
         repeat (4) @(negedge clk);
         sclk = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   // Send one full byte with CS low, advance the model and check every observable output
   task automatic applyStimulus(input bit isData, input logic [7:0] b, output int gotUnk);
      int v0;
      int u0;
      int expUnk;
      v0 = validCount;
      u0 = unkCount;
      cs_n = 1'b0;
      shiftBits(isData, b, 8);
      repeat (4) @(negedge clk);
      modelByte(isData, b, expUnk);
      gotUnk = unkCount - u0;
      checkOutput("validPulses", validCount - v0, 1);
      checkOutput("byteData", int'(byteData), int'(b));
      checkOutput("byteDc", int'(byteDc), int'(isData));
      checkOutput("cmdUnkPulses", gotUnk, expUnk);
      checkOutput("curPage", int'(curPage), mPage);
      checkOutput("curCol", int'(curCol), mCol);
      checkOutput("dispOn", int'(dispOn), int'(mDisp));
   endtask

   task automatic readMem(input int addr, output logic [7:0] data);
      @(negedge clk);
      rdAddr = addr[8:0];
      @(negedge clk);
      data = rdData;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".curPage"}, int'(curPage), 0);
      checkOutput({tag, ".curCol"}, int'(curCol), 0);
      checkOutput({tag, ".byteData"}, int'(byteData), 0);
      checkOutput({tag, ".byteDc"}, int'(byteDc), 0);
      checkOutput({tag, ".byteValid"}, int'(byteValid), 0);
      checkOutput({tag, ".cmdUnk"}, int'(cmdUnk), 0);
      checkOutput({tag, ".rdData"}, int'(rdData), 0);
      checkOutput({tag, ".dispOn"}, int'(dispOn), int'(resetDisp));
   endtask

   initial begin
      vec_t       vecs [16];
      int         gotUnk;
      int         vp;
      logic [7:0] rd;
      logic [7:0] rb;
      int         sel;

      vecs[0]  = '{1'b0, 8'h22, 0, 8'h00, 0, -1, 0};
      vecs[1]  = '{1'b0, 8'h02, 2, 8'h00, 0, -1, 0};
      vecs[2]  = '{1'b0, 8'h00, 2, 8'h00, 0, -1, 0};
      vecs[3]  = '{1'b0, 8'h10, 2, 8'h00, 0, -1, 0};
      vecs[4]  = '{1'b1, 8'hA5, 2, 8'h01, 0, 'h100, 'hA5};
      vecs[5]  = '{1'b0, 8'h22, 2, 8'h01, 0, -1, 0};
      vecs[6]  = '{1'b0, 8'h01, 1, 8'h01, 0, -1, 0};
      vecs[7]  = '{1'b0, 8'h0F, 1, 8'h0F, 0, -1, 0};
      vecs[8]  = '{1'b0, 8'h17, 1, 8'h7F, 0, -1, 0};
      vecs[9]  = '{1'b1, 8'h11, 1, 8'h00, 0, 'h0FF, 'h11};
      vecs[10] = '{1'b1, 8'h22, 1, 8'h01, 0, 'h080, 'h22};
      vecs[11] = '{1'b0, 8'h22, 1, 8'h01, 0, -1, 0};
      vecs[12] = '{1'b1, 8'h77, 1, 8'h02, 0, 'h081, 'h77};
      vecs[13] = '{1'b0, 8'h03, 1, 8'h03, 0, -1, 0};
      vecs[14] = '{1'b0, 8'h81, 1, 8'h03, 1, -1, 0};
      vecs[15] = '{1'b0, 8'h40, 1, 8'h03, 1, -1, 0};

      for (int i = 0; i < 512; i++) mWritten[i] = 1'b0;
      modelReset();

      rst_n = 1'b0;
      cs_n = 1'b1;
      sclk = 1'b1;
      sdo = 1'b0;
      dc = 1'b0;
      rdAddr = 9'd0;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Test-plan sequences: page set, column wrap, page-arg abort, unknown commands
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i].isData, vecs[i].b, gotUnk);
         checkOutput($sformatf("vec%0d.page", i), int'(curPage), vecs[i].expPage);
         checkOutput($sformatf("vec%0d.col", i), int'(curCol), vecs[i].expCol);
         checkOutput($sformatf("vec%0d.unk", i), gotUnk, vecs[i].expUnk);
         if (vecs[i].chkAddr >= 0) begin
            readMem(vecs[i].chkAddr, rd);
            checkOutput($sformatf("vec%0d.mem", i), int'(rd), vecs[i].chkData);
         end
      end

      // Display commands: 0xAF then 0x81
      vp = unkCount;
      applyStimulus(1'b0, 8'hAF, gotUnk);
      applyStimulus(1'b0, 8'h81, gotUnk);
      checkOutput("dispSeq.unkPulses", unkCount - vp, dispCmdEn ? 1 : 2);
      checkOutput("dispSeq.dispOn", int'(dispOn), 1);

      // Partial byte discarded when CS rises, then one clean byte
      vp = validCount;
      cs_n = 1'b0;
      shiftBits(1'b1, 8'hFF, 5);
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
      applyStimulus(1'b1, 8'h3C, gotUnk);
      checkOutput("partial.validTotal", validCount - vp, 1);
      checkOutput("partial.byteData", int'(byteData), 'h3C);

      // Read and write of the same address in one cycle returns the old data
      applyStimulus(1'b0, 8'h22, gotUnk);
      applyStimulus(1'b0, 8'h02, gotUnk);
      applyStimulus(1'b0, 8'h00, gotUnk);
      applyStimulus(1'b0, 8'h10, gotUnk);
      @(negedge clk);
      rdAddr = 9'h100;
      applyStimulus(1'b1, 8'h5C, gotUnk);
      checkOutput("rdWrCollision.old", int'(rdAfterValid), 'hA5);
      readMem('h100, rd);
      checkOutput("rdWrCollision.new", int'(rd), 'h5C);

      // Randomised stream against the model
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(0, 9);
         if (sel <= 3) begin
            applyStimulus(1'b1, 8'($urandom), gotUnk);
         end else if (sel <= 5) begin
            applyStimulus(1'b0, 8'($urandom_range(0, 31)), gotUnk);
         end else if (sel == 6) begin
            applyStimulus(1'b0, 8'h22, gotUnk);
         end else if (sel == 7) begin
            applyStimulus(1'b0, 8'($urandom), gotUnk);
         end else begin
            applyStimulus(1'b0, ($urandom_range(0, 1) != 0) ? 8'hAF : 8'hAE, gotUnk);
         end
      end

      // Reset in the middle of bit 4 of a data byte
      cs_n = 1'b0;
      shiftBits(1'b1, 8'hF0, 3);
      sclk = 1'b0;
      sdo = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checkResetOutputs("midReset");
      sclk = 1'b1;
      cs_n = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      modelReset();
      applyStimulus(1'b0, 8'h05, gotUnk);
      applyStimulus(1'b1, 8'h5A, gotUnk);
      readMem('h005, rd);
      checkOutput("midReset.mem", int'(rd), 'h5A);

      // Full frame buffer sweep of every model-written location
      for (int a = 0; a < 512; a++) begin
         if (mWritten[a]) begin
            readMem(a, rb);
            checkOutput($sformatf("mem[0x%0h]", a), int'(rb), int'(mMem[a]));
         end
      end

      checkOutput("strayCmdUnk", strayUnk, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, failures);
      $finish;
   end

endmodule
